// File: rtl/sound_pkg.sv
// Shared constants and types for the 68k<->Z80 sound mailbox.
package sound_pkg;

    localparam int unsigned SOUND_DW        = 8;
    localparam int unsigned SOUND_CMD_DEPTH = 4;

    localparam logic SOUND_IRQ_N_RST = 1'b1;
    localparam logic SOUND_FLAG_RST  = 1'b0;

    // One-cycle bus events derived from the chip-select level terms.
    typedef struct packed {
        logic w68;
        logic r68;
        logic rz;
        logic wz;
        logic ack;
    } sound_evt_t;

    localparam int unsigned SOUND_NTERM = 5;

endpackage

// File: rtl/sound_cmd_fifo.sv
// Command FIFO for the sound mailbox; a push while full is accepted only with a pop.
module sound_cmd_fifo
    import sound_pkg::*;
#(
    parameter int unsigned DW    = SOUND_DW,
    parameter int unsigned DEPTH = SOUND_CMD_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sound_mailbox.sv
// 68k<->Z80 sound command/reply mailbox with edge-derived bus events.
// SOUND_CMD_FIFO_EN selects a CMD_DEPTH command FIFO instead of the single latch.
module sound_mailbox
    import sound_pkg::*;
#(
    parameter int unsigned DW        = SOUND_DW,
    parameter int unsigned CMD_DEPTH = SOUND_CMD_DEPTH
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m68k_latch_cs,
    input  logic          m68k_sound_cs,
    input  logic [DW-1:0] m68k_dout,
    output logic [DW-1:0] m68k_din,
    input  logic          z80_latch_cs,
    input  logic          RD_n,
    input  logic          WR_n,
    input  logic          M1_n,
    input  logic          IORQ_n,
    input  logic [DW-1:0] z80_dout,
    output logic [DW-1:0] z80_din,
    output logic          z80_irq_n,
    output logic          cmd_pending,
    output logic          reply_pending,
    output logic          cmd_overrun
);

    if ((CMD_DEPTH < 2) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("CMD_DEPTH must be a power of two and at least 2");
    end

    logic [SOUND_NTERM-1:0] lvl;
    logic [SOUND_NTERM-1:0] lvl_q;
    logic [SOUND_NTERM-1:0] lvl_qq;
    logic [SOUND_NTERM-1:0] rise_v;
    logic [SOUND_NTERM-1:0] fall_v;
    logic [1:0]             arm;
    sound_evt_t             evt;
    logic [DW-1:0]          reply;
    logic                   irq_n_q;

    assign lvl = {m68k_latch_cs, m68k_sound_cs, z80_latch_cs & ~RD_n,
                  z80_latch_cs & ~WR_n, ~M1_n & ~IORQ_n};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q  <= '0;
            lvl_qq <= '0;
            arm    <= '0;
        end else begin
            lvl_q  <= lvl;
            lvl_qq <= lvl_q;
            arm    <= {arm[0], 1'b1};
        end
    end

    assign rise_v = lvl_q & ~lvl_qq;
    assign fall_v = ~lvl_q & lvl_qq;

    // Rises are held off until both edge stages have seen a post-reset sample,
    // so a strobe held across reset release does not look like a new edge.
    always_comb begin
        evt     = '0;
        evt.w68 = arm[1] & rise_v[4];
        evt.r68 = fall_v[3];
        evt.rz  = fall_v[2];
        evt.wz  = arm[1] & rise_v[1];
        evt.ack = arm[1] & rise_v[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reply         <= '0;
            reply_pending <= SOUND_FLAG_RST;
        end else if (evt.wz) begin
            reply         <= z80_dout;
            reply_pending <= 1'b1;
        end else if (evt.r68) begin
            reply_pending <= 1'b0;
        end
    end

    assign m68k_din  = reply;
    assign z80_irq_n = irq_n_q;

`ifdef SOUND_CMD_FIFO_EN
    localparam int unsigned CNT_W = $clog2(CMD_DEPTH) + 1;

    logic [DW-1:0]    fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    sound_cmd_fifo #(
        .DW    (DW),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (evt.w68),
        .pop     (evt.rz),
        .din     (m68k_dout),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_n_q     <= SOUND_IRQ_N_RST;
            cmd_overrun <= SOUND_FLAG_RST;
        end else begin
            if (evt.w68 && fifo_full && !evt.rz) begin
                cmd_overrun <= 1'b1;
            end
            if (evt.w68) begin
                irq_n_q <= 1'b0;
            end else if (evt.rz) begin
                irq_n_q <= (fifo_count <= CNT_W'(1));
            end else if (evt.ack) begin
                irq_n_q <= 1'b1;
            end
        end
    end

    assign z80_din     = fifo_head;
    assign cmd_pending = ~fifo_empty;
`else
    logic [DW-1:0] cmd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd         <= '0;
            cmd_pending <= SOUND_FLAG_RST;
            cmd_overrun <= SOUND_FLAG_RST;
            irq_n_q     <= SOUND_IRQ_N_RST;
        end else if (evt.w68) begin
            cmd         <= m68k_dout;
            cmd_pending <= 1'b1;
            irq_n_q     <= 1'b0;
            if (cmd_pending && !evt.rz) begin
                cmd_overrun <= 1'b1;
            end
        end else if (evt.rz) begin
            cmd_pending <= 1'b0;
            irq_n_q     <= 1'b1;
        end else if (evt.ack) begin
            irq_n_q <= 1'b1;
        end
    end

    assign z80_din = cmd;
`endif

endmodule

// File: tb/tb_sound_mailbox.sv
// Directed self-checking bench for sound_mailbox; define SOUND_CMD_FIFO_EN for FIFO checks.
module tb_sound_mailbox;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       m68k_latch_cs;
    logic       m68k_sound_cs;
    logic [7:0] m68k_dout;
    logic [7:0] m68k_din;
    logic       z80_latch_cs;
    logic       RD_n;
    logic       WR_n;
    logic       M1_n;
    logic       IORQ_n;
    logic [7:0] z80_dout;
    logic [7:0] z80_din;
    logic       z80_irq_n;
    logic       cmd_pending;
    logic       reply_pending;
    logic       cmd_overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sound_mailbox #(.DW(8), .CMD_DEPTH(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .m68k_latch_cs (m68k_latch_cs),
        .m68k_sound_cs (m68k_sound_cs),
        .m68k_dout     (m68k_dout),
        .m68k_din      (m68k_din),
        .z80_latch_cs  (z80_latch_cs),
        .RD_n          (RD_n),
        .WR_n          (WR_n),
        .M1_n          (M1_n),
        .IORQ_n        (IORQ_n),
        .z80_dout      (z80_dout),
        .z80_din       (z80_din),
        .z80_irq_n     (z80_irq_n),
        .cmd_pending   (cmd_pending),
        .reply_pending (reply_pending),
        .cmd_overrun   (cmd_overrun)
    );

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic m68_write(input logic [7:0] d, input int hold);
        m68k_dout     = d;
        m68k_latch_cs = 1'b1;
        ticks(hold);
        m68k_latch_cs = 1'b0;
        ticks(3);
    endtask

    task automatic m68_read();
        m68k_sound_cs = 1'b1;
        ticks(3);
        m68k_sound_cs = 1'b0;
        ticks(3);
    endtask

    task automatic z80_read(output logic [7:0] d);
        z80_latch_cs = 1'b1;
        RD_n         = 1'b0;
        ticks(3);
        d            = z80_din;
        RD_n         = 1'b1;
        z80_latch_cs = 1'b0;
        ticks(3);
    endtask

    task automatic z80_write(input logic [7:0] d);
        z80_dout     = d;
        z80_latch_cs = 1'b1;
        WR_n         = 1'b0;
        ticks(3);
        WR_n         = 1'b1;
        z80_latch_cs = 1'b0;
        ticks(3);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ticks(3);
        checks++; if (z80_irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n got=%b exp=1", z80_irq_n); end
        checks++; if (cmd_pending !== 1'b0) begin errors++; $display("FAIL reset_cmd_pending got=%b exp=0", cmd_pending); end
        checks++; if (reply_pending !== 1'b0) begin errors++; $display("FAIL reset_reply_pending got=%b exp=0", reply_pending); end
        checks++; if (cmd_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", cmd_overrun); end
        checks++; if (z80_din !== 8'h00) begin errors++; $display("FAIL reset_z80_din got=%h exp=00", z80_din); end
        checks++; if (m68k_din !== 8'h00) begin errors++; $display("FAIL reset_m68k_din got=%h exp=00", m68k_din); end
        reset_n = 1'b1;
        ticks(3);
    endtask

    task automatic test_command();
        logic [7:0] d;
        m68k_dout     = 8'h5A;
        m68k_latch_cs = 1'b1;
        ticks(1);
        checks++; if (cmd_pending !== 1'b0) begin errors++; $display("FAIL cmd_latency1_pending got=%b exp=0", cmd_pending); end
        checks++; if (z80_irq_n !== 1'b1) begin errors++; $display("FAIL cmd_latency1_irq got=%b exp=1", z80_irq_n); end
        ticks(1);
        checks++; if (cmd_pending !== 1'b1) begin errors++; $display("FAIL cmd_latency2_pending got=%b exp=1", cmd_pending); end
        checks++; if (z80_irq_n !== 1'b0) begin errors++; $display("FAIL cmd_latency2_irq got=%b exp=0", z80_irq_n); end
        ticks(4);
        m68k_latch_cs = 1'b0;
        ticks(2);
        z80_read(d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL cmd_read_data got=%h exp=5a", d); end
        checks++; if (cmd_pending !== 1'b0) begin errors++; $display("FAIL cmd_read_pending got=%b exp=0", cmd_pending); end
        checks++; if (z80_irq_n !== 1'b1) begin errors++; $display("FAIL cmd_read_irq got=%b exp=1", z80_irq_n); end
    endtask

    task automatic test_ack();
        logic [7:0] d;
        m68_write(8'h33, 4);
        checks++; if (z80_irq_n !== 1'b0) begin errors++; $display("FAIL ack_pre_irq got=%b exp=0", z80_irq_n); end
        M1_n   = 1'b0;
        IORQ_n = 1'b0;
        ticks(2);
        checks++; if (z80_irq_n !== 1'b1) begin errors++; $display("FAIL ack_irq got=%b exp=1", z80_irq_n); end
        checks++; if (cmd_pending !== 1'b1) begin errors++; $display("FAIL ack_pending got=%b exp=1", cmd_pending); end
        M1_n   = 1'b1;
        IORQ_n = 1'b1;
        ticks(2);
        z80_read(d);
        checks++; if (d !== 8'h33) begin errors++; $display("FAIL ack_read_data got=%h exp=33", d); end
        checks++; if (cmd_pending !== 1'b0) begin errors++; $display("FAIL ack_read_pending got=%b exp=0", cmd_pending); end
    endtask

    task automatic test_write_read_collision();
        logic [7:0] d;
        m68_write(8'h47, 4);
        z80_latch_cs = 1'b1;
        RD_n         = 1'b0;
        ticks(3);
        RD_n          = 1'b1;
        z80_latch_cs  = 1'b0;
        m68k_dout     = 8'h99;
        m68k_latch_cs = 1'b1;
        ticks(2);
        checks++; if (cmd_pending !== 1'b1) begin errors++; $display("FAIL coll_pending got=%b exp=1", cmd_pending); end
        checks++; if (z80_irq_n !== 1'b0) begin errors++; $display("FAIL coll_irq got=%b exp=0", z80_irq_n); end
        checks++; if (cmd_overrun !== 1'b0) begin errors++; $display("FAIL coll_overrun got=%b exp=0", cmd_overrun); end
        checks++; if (z80_din !== 8'h99) begin errors++; $display("FAIL coll_din got=%h exp=99", z80_din); end
        ticks(2);
        m68k_latch_cs = 1'b0;
        ticks(2);
        z80_read(d);
        checks++; if (d !== 8'h99) begin errors++; $display("FAIL coll_read_data got=%h exp=99", d); end
        checks++; if (cmd_pending !== 1'b0) begin errors++; $display("FAIL coll_read_pending got=%b exp=0", cmd_pending); end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        m68_write(8'h11, 4);
        m68_write(8'h22, 4);
        checks++; if (z80_din !== 8'h22) begin errors++; $display("FAIL ovr_din got=%h exp=22", z80_din); end
        checks++; if (cmd_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", cmd_overrun); end
        z80_read(d);
        checks++; if (d !== 8'h22) begin errors++; $display("FAIL ovr_read_data got=%h exp=22", d); end
        checks++; if (cmd_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", cmd_overrun); end
        reset_n = 1'b0;
        ticks(1);
        reset_n = 1'b1;
        ticks(3);
        checks++; if (cmd_overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared got=%b exp=0", cmd_overrun); end
    endtask

    task automatic test_reply();
        z80_write(8'hC3);
        checks++; if (reply_pending !== 1'b1) begin errors++; $display("FAIL reply_pending got=%b exp=1", reply_pending); end
        checks++; if (m68k_din !== 8'hC3) begin errors++; $display("FAIL reply_data got=%h exp=c3", m68k_din); end
        m68_read();
        checks++; if (reply_pending !== 1'b0) begin errors++; $display("FAIL reply_clear got=%b exp=0", reply_pending); end
        z80_write(8'h44);
        m68k_sound_cs = 1'b1;
        ticks(3);
        m68k_sound_cs = 1'b0;
        z80_dout      = 8'h7E;
        z80_latch_cs  = 1'b1;
        WR_n          = 1'b0;
        ticks(2);
        checks++; if (reply_pending !== 1'b1) begin errors++; $display("FAIL reply_collide_pending got=%b exp=1", reply_pending); end
        checks++; if (m68k_din !== 8'h7E) begin errors++; $display("FAIL reply_collide_data got=%h exp=7e", m68k_din); end
        ticks(1);
        WR_n         = 1'b1;
        z80_latch_cs = 1'b0;
        ticks(3);
        checks++; if (reply_pending !== 1'b1) begin errors++; $display("FAIL reply_collide_hold got=%b exp=1", reply_pending); end
    endtask

    task automatic test_reset_mid_write();
        m68_write(8'h66, 4);
        m68k_dout     = 8'hA5;
        m68k_latch_cs = 1'b1;
        ticks(1);
        reset_n = 1'b0;
        #1;
        checks++; if (cmd_pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending got=%b exp=0", cmd_pending); end
        checks++; if (z80_irq_n !== 1'b1) begin errors++; $display("FAIL rstmid_irq got=%b exp=1", z80_irq_n); end
        checks++; if (reply_pending !== 1'b0) begin errors++; $display("FAIL rstmid_reply got=%b exp=0", reply_pending); end
        checks++; if (z80_din !== 8'h00) begin errors++; $display("FAIL rstmid_z80_din got=%h exp=00", z80_din); end
        checks++; if (m68k_din !== 8'h00) begin errors++; $display("FAIL rstmid_m68k_din got=%h exp=00", m68k_din); end
        ticks(2);
        reset_n = 1'b1;
        ticks(5);
        checks++; if (cmd_pending !== 1'b0) begin errors++; $display("FAIL rstrel_pending got=%b exp=0", cmd_pending); end
        checks++; if (z80_irq_n !== 1'b1) begin errors++; $display("FAIL rstrel_irq got=%b exp=1", z80_irq_n); end
        checks++; if (z80_din !== 8'h00) begin errors++; $display("FAIL rstrel_din got=%h exp=00", z80_din); end
        m68k_latch_cs = 1'b0;
        ticks(3);
    endtask

`ifdef SOUND_CMD_FIFO_EN
    task automatic test_fifo();
        logic [7:0] d;
        for (int i = 1; i <= 5; i++) begin
            m68_write(8'(i), 3);
        end
        checks++; if (cmd_overrun !== 1'b1) begin errors++; $display("FAIL fifo_overrun got=%b exp=1", cmd_overrun); end
        checks++; if (z80_din !== 8'h01) begin errors++; $display("FAIL fifo_head got=%h exp=01", z80_din); end
        checks++; if (z80_irq_n !== 1'b0) begin errors++; $display("FAIL fifo_irq got=%b exp=0", z80_irq_n); end
        for (int i = 1; i <= 4; i++) begin
            z80_read(d);
            checks++; if (d !== 8'(i)) begin errors++; $display("FAIL fifo_read%0d got=%h exp=%h", i, d, 8'(i)); end
            checks++; if (z80_irq_n !== (i == 4)) begin errors++; $display("FAIL fifo_irq%0d got=%b exp=%b", i, z80_irq_n, (i == 4)); end
            checks++; if (cmd_pending !== (i != 4)) begin errors++; $display("FAIL fifo_pend%0d got=%b exp=%b", i, cmd_pending, (i != 4)); end
        end
    endtask
`endif

    initial begin
        reset_n       = 1'b0;
        m68k_latch_cs = 1'b0;
        m68k_sound_cs = 1'b0;
        m68k_dout     = 8'h00;
        z80_latch_cs  = 1'b0;
        RD_n          = 1'b1;
        WR_n          = 1'b1;
        M1_n          = 1'b1;
        IORQ_n        = 1'b1;
        z80_dout      = 8'h00;
        test_reset();
        test_command();
        test_ack();
        test_write_read_collision();
`ifndef SOUND_CMD_FIFO_EN
        test_overrun();
`endif
        test_reply();
        test_reset_mid_write();
`ifdef SOUND_CMD_FIFO_EN
        test_fifo();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
